vga_scan_engine: RTL and testbench
==================================

Name: vga_scan_engine

Overview:
Parametrised successor to the fixed 640x480 VGA output stage. It generates pixel ticks from sysclk with a programmable divider, runs the horizontal and vertical scan counters, and issues pixel addresses to the container switcher. It then drives VGA_R/G/B/HS/VS with a configurable fetch-latency compensation pipeline, configurable sync polarity and per-channel colour width, and emits frame and line strobes for function blocks.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (ticks)
H_SYNC, 96, horizontal sync width (ticks)
H_BP, 48, horizontal back porch (ticks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
CLK_DIV, 2, sysclk cycles per pixel tick (>=1)
FETCH_LAT, 1, pixel ticks from pixel_addr to valid pixel_data (0..4)
COLOR_W, 1, bits per colour channel
X_W, 11, x field width of pixel_addr
Y_W, 11, y field width of pixel_addr
HS_POL, 0, active level of VGA_HS
VS_POL, 0, active level of VGA_VS

Ports:
sysclk  in  1  system clock; all logic on its rising edge
rst  in  1  asynchronous reset, active-low
en  in  1  scan enable; low freezes the scan
pixel_data  in  3*COLOR_W  {R,G,B} for the address issued FETCH_LAT ticks earlier
pixel_addr  out  X_W+Y_W  {y,x} of the position being fetched
pixel_valid  out  1  pixel_addr lies inside the active area
VGA_R  out  COLOR_W  red
VGA_G  out  COLOR_W  green
VGA_B  out  COLOR_W  blue
VGA_HS  out  1  horizontal sync
VGA_VS  out  1  vertical sync
blank  out  1  current output pixel is outside the active area
line_start  out  1  one-sysclk strobe when x=0 is issued
frame_start  out  1  one-sysclk strobe when (0,0) is issued

Behaviour:
- Reset is asynchronous and active-low: rst=0 immediately forces all registers to their reset values.
- Reset values:
  - prescaler=0, h_cnt=0, v_cnt=0, pixel_addr=0, pixel_valid=0.
  - VGA_R/G/B=0, VGA_HS=~HS_POL, VGA_VS=~VS_POL, blank=1.
  - line_start=0, frame_start=0.
  - Every delay-line stage is set to the inactive state: blank=1, syncs inactive.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Prescaler:
  - Counts 0..CLK_DIV-1 while en=1.
  - tick=1 when prescaler=CLK_DIV-1; CLK_DIV=1 gives tick every cycle.
  - en=0 holds the prescaler, both counters and every output register. The strobes are forced to 0 while en=0.
- On each tick, stage 0 runs:
  - Register the current (h_cnt, v_cnt): pixel_addr <= {v_cnt[Y_W-1:0], h_cnt[X_W-1:0]}.
  - pixel_valid <= (h_cnt<H_ACTIVE && v_cnt<V_ACTIVE).
  - Advance h_cnt. At H_TOTAL-1 it wraps to 0 and v_cnt advances. v_cnt wraps from V_TOTAL-1 to 0.
  - The first tick after reset issues (0,0).
- Strobes:
  - line_start=1 for exactly the sysclk cycle following a tick that issued h=0.
  - frame_start=1 likewise for a tick that issued (0,0), including the first tick after reset.
- Stage-0 sync decode for the issued position:
  - hs_act = H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vs_act = V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
- Delay line:
  - pixel_valid, hs_act and vs_act pass through a FETCH_LAT-stage shift register that advances only on ticks.
  - The output register then updates on the tick FETCH_LAT ticks after issue.
  - VGA_R/G/B <= delayed_valid ? pixel_data fields : 0. pixel_data is sampled only on that tick.
  - VGA_HS <= delayed_hs ? HS_POL : ~HS_POL; VGA_VS likewise; blank <= ~delayed_valid.
  - FETCH_LAT=0: outputs update on the same tick as pixel_addr and pixel_data is assumed combinational from the address.
- Output timing: all outputs are registered and change only in the sysclk cycle following a tick.
- Latency: position issued on tick n appears on the VGA pins after tick n+FETCH_LAT, so HS/VS stay aligned to RGB at any FETCH_LAT.
- en deasserted mid-line: the scan resumes from the exact held position with no skipped or repeated pixel.
- rst asserted mid-frame:
  - Immediate return to the reset values and a flushed pipeline.
  - The next frame starts at (0,0) with a frame_start strobe.
- pixel_addr widths: fields are the low X_W/Y_W bits of the counters, so blanking positions may alias. pixel_valid qualifies them.

Test Plan:
- Reset: hold rst=0, then release with en=1 and default parameters.
  - During reset: RGB=0, HS=VS=1, blank=1, pixel_addr=0.
  - frame_start and line_start pulse once, exactly 2 sysclk after release (CLK_DIV=2).
- Default horizontal timing: VGA_HS low for 192 sysclk (96 ticks) starting 656 ticks after line issue+FETCH_LAT; line period 1600 sysclk.
  - VS low for 2 lines starting at line 490; frame period 420000 ticks.
- Small parameters with a model memory returning data=f(addr): H_ACTIVE=4, H_FP=1, H_SYNC=1, H_BP=1, V_ACTIVE=3, V_FP=V_SYNC=V_BP=1, CLK_DIV=1, FETCH_LAT=2.
  - pixel_addr sequence is x 0..6 per line and y 0..5.
  - RGB equals f(addr) exactly 2 ticks after issue and 0 in blanking.
  - HS coincides with delayed x=5.
- Freeze: en=0 for 10 cycles at x=2.
  - All outputs hold and the strobes stay 0.
  - After en=1 the next issued x=3.
- Mid-frame reset: assert rst at line 200, release.
  - Outputs return to reset values immediately; pixel_addr restarts at 0; frame_start pulses.
- Polarity and width: HS_POL=1, VS_POL=1, COLOR_W=4, pixel_data=12'hA5C in the active area.
  - HS/VS pulses are high; VGA_R=4'hA, VGA_G=4'h5, VGA_B=4'hC.

Source files
------------

// File: rtl/vga_scan_engine.sv
// Parametrised VGA scan engine: pixel-tick prescaler, h/v scan counters, address issue,
// fetch-latency delay line and registered RGB/sync/blank outputs with frame/line strobes.
module vga_scan_engine #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned FETCH_LAT = 1,
  parameter int unsigned COLOR_W   = 1,
  parameter int unsigned X_W       = 11,
  parameter int unsigned Y_W       = 11,
  parameter bit          HS_POL    = 1'b0,
  parameter bit          VS_POL    = 1'b0
) (
  input  logic                   sysclk_i,
  input  logic                   rst_ni,
  input  logic                   en_i,
  input  logic [3*COLOR_W-1:0]   pixel_data_i,
  output logic [X_W+Y_W-1:0]     pixel_addr_o,
  output logic                   pixel_valid_o,
  output logic [COLOR_W-1:0]     vga_r_o,
  output logic [COLOR_W-1:0]     vga_g_o,
  output logic [COLOR_W-1:0]     vga_b_o,
  output logic                   vga_hs_o,
  output logic                   vga_vs_o,
  output logic                   blank_o,
  output logic                   line_start_o,
  output logic                   frame_start_o
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned PW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  // Counters are at least as wide as the address fields so slicing is always legal.
  localparam int unsigned HCW = ($clog2(H_TOTAL) > X_W) ? $clog2(H_TOTAL) : X_W;
  localparam int unsigned VCW = ($clog2(V_TOTAL) > Y_W) ? $clog2(V_TOTAL) : Y_W;
  localparam int unsigned LW  = (FETCH_LAT > 0) ? FETCH_LAT : 1;

  logic [PW-1:0]        presc_q, presc_d;
  logic [HCW-1:0]       h_cnt_q, h_cnt_d;
  logic [VCW-1:0]       v_cnt_q, v_cnt_d;
  logic [X_W+Y_W-1:0]   addr_q, addr_d;
  logic                 valid_q, valid_d;
  logic [LW-1:0]        dl_valid_q, dl_valid_d, dl_hs_q, dl_hs_d, dl_vs_q, dl_vs_d;
  logic [COLOR_W-1:0]   r_q, r_d, g_q, g_d, b_q, b_d;
  logic                 hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
  logic                 ls_q, ls_d, fs_q, fs_d;
  logic                 tick, valid_c, hs_c, vs_c, dvalid, dhs, dvs;

  assign tick = en_i && (presc_q == PW'(CLK_DIV - 1));

  // Decode of the position being issued on this tick.
  assign valid_c = (h_cnt_q < HCW'(H_ACTIVE)) && (v_cnt_q < VCW'(V_ACTIVE));
  assign hs_c    = (h_cnt_q >= HCW'(HS_START)) && (h_cnt_q < HCW'(HS_END));
  assign vs_c    = (v_cnt_q >= VCW'(VS_START)) && (v_cnt_q < VCW'(VS_END));

  assign dvalid = (FETCH_LAT == 0) ? valid_c : dl_valid_q[LW-1];
  assign dhs    = (FETCH_LAT == 0) ? hs_c    : dl_hs_q[LW-1];
  assign dvs    = (FETCH_LAT == 0) ? vs_c    : dl_vs_q[LW-1];

  always_comb begin
    presc_d    = presc_q;
    h_cnt_d    = h_cnt_q;
    v_cnt_d    = v_cnt_q;
    addr_d     = addr_q;
    valid_d    = valid_q;
    dl_valid_d = dl_valid_q;
    dl_hs_d    = dl_hs_q;
    dl_vs_d    = dl_vs_q;
    r_d        = r_q;
    g_d        = g_q;
    b_d        = b_q;
    hs_d       = hs_q;
    vs_d       = vs_q;
    blank_d    = blank_q;
    ls_d       = tick && (h_cnt_q == '0);
    fs_d       = tick && (h_cnt_q == '0) && (v_cnt_q == '0);
    if (en_i) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end
    if (tick) begin
      addr_d  = {v_cnt_q[Y_W-1:0], h_cnt_q[X_W-1:0]};
      valid_d = valid_c;
      if (h_cnt_q == HCW'(H_TOTAL - 1)) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == VCW'(V_TOTAL - 1)) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
      dl_valid_d[0] = valid_c;
      dl_hs_d[0]    = hs_c;
      dl_vs_d[0]    = vs_c;
      for (int i = 1; i < LW; i++) begin
        dl_valid_d[i] = dl_valid_q[i-1];
        dl_hs_d[i]    = dl_hs_q[i-1];
        dl_vs_d[i]    = dl_vs_q[i-1];
      end
      r_d     = dvalid ? pixel_data_i[3*COLOR_W-1:2*COLOR_W] : '0;
      g_d     = dvalid ? pixel_data_i[2*COLOR_W-1:COLOR_W]   : '0;
      b_d     = dvalid ? pixel_data_i[COLOR_W-1:0]           : '0;
      hs_d    = dhs ? HS_POL : ~HS_POL;
      vs_d    = dvs ? VS_POL : ~VS_POL;
      blank_d = ~dvalid;
    end
  end

  always_ff @(posedge sysclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q    <= '0;
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      addr_q     <= '0;
      valid_q    <= 1'b0;
      dl_valid_q <= '0;
      dl_hs_q    <= '0;
      dl_vs_q    <= '0;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
      hs_q       <= ~HS_POL;
      vs_q       <= ~VS_POL;
      blank_q    <= 1'b1;
      ls_q       <= 1'b0;
      fs_q       <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      dl_valid_q <= dl_valid_d;
      dl_hs_q    <= dl_hs_d;
      dl_vs_q    <= dl_vs_d;
      r_q        <= r_d;
      g_q        <= g_d;
      b_q        <= b_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      blank_q    <= blank_d;
      ls_q       <= ls_d;
      fs_q       <= fs_d;
    end
  end

  assign pixel_addr_o  = addr_q;
  assign pixel_valid_o = valid_q;
  assign vga_r_o       = r_q;
  assign vga_g_o       = g_q;
  assign vga_b_o       = b_q;
  assign vga_hs_o      = hs_q;
  assign vga_vs_o      = vs_q;
  assign blank_o       = blank_q;
  assign line_start_o  = ls_q;
  assign frame_start_o = fs_q;

endmodule

// File: tb/tb_vga_scan_engine.sv
// Bench for vga_scan_engine: default timing, a tiny-timing instance with a one-register model
// memory, and a positive-polarity 4-bit-colour instance.
module tb_vga_scan_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- default-parameter instance ----------------
  logic        rst_def_n, en_def;
  logic [21:0] addr_def;
  logic        valid_def, r_def, g_def, b_def, hs_def, vs_def, blank_def, ls_def, fs_def;
  logic [2:0]  data_def = 3'b101;

  vga_scan_engine u_def (
    .sysclk_i(clk), .rst_ni(rst_def_n), .en_i(en_def), .pixel_data_i(data_def),
    .pixel_addr_o(addr_def), .pixel_valid_o(valid_def), .vga_r_o(r_def), .vga_g_o(g_def),
    .vga_b_o(b_def), .vga_hs_o(hs_def), .vga_vs_o(vs_def), .blank_o(blank_def),
    .line_start_o(ls_def), .frame_start_o(fs_def)
  );

  // ---------------- small-timing instance, FETCH_LAT=2 ----------------
  logic       rst_sml_n, en_sml;
  logic [5:0] addr_sml;
  logic       valid_sml, r_sml, g_sml, b_sml, hs_sml, vs_sml, blank_sml, ls_sml, fs_sml;
  logic [2:0] mem_q;

  vga_scan_engine #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1), .V_ACTIVE(3), .V_FP(1), .V_SYNC(1),
    .V_BP(1), .CLK_DIV(1), .FETCH_LAT(2), .COLOR_W(1), .X_W(3), .Y_W(3)
  ) u_sml (
    .sysclk_i(clk), .rst_ni(rst_sml_n), .en_i(en_sml), .pixel_data_i(mem_q),
    .pixel_addr_o(addr_sml), .pixel_valid_o(valid_sml), .vga_r_o(r_sml), .vga_g_o(g_sml),
    .vga_b_o(b_sml), .vga_hs_o(hs_sml), .vga_vs_o(vs_sml), .blank_o(blank_sml),
    .line_start_o(ls_sml), .frame_start_o(fs_sml)
  );

  function automatic logic [2:0] f_mem(input logic [5:0] a);
    return a[2:0] + {a[4:3], 1'b0} + 3'd1;  // x + 2*y + 1
  endfunction

  // One register of fetch latency: with FETCH_LAT=2 the DUT samples f(addr issued 2 ticks ago).
  always @(posedge clk) begin
    if (en_sml) mem_q <= f_mem(addr_sml);
  end

  // ---------------- polarity / colour-width instance ----------------
  logic        rst_pol_n, en_pol;
  logic [5:0]  addr_pol;
  logic [3:0]  r_pol, g_pol, b_pol;
  logic        valid_pol, hs_pol, vs_pol, blank_pol, ls_pol, fs_pol;
  logic [11:0] data_pol = 12'hA5C;

  vga_scan_engine #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1), .V_ACTIVE(3), .V_FP(1), .V_SYNC(1),
    .V_BP(1), .CLK_DIV(1), .FETCH_LAT(1), .COLOR_W(4), .X_W(3), .Y_W(3),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_pol (
    .sysclk_i(clk), .rst_ni(rst_pol_n), .en_i(en_pol), .pixel_data_i(data_pol),
    .pixel_addr_o(addr_pol), .pixel_valid_o(valid_pol), .vga_r_o(r_pol), .vga_g_o(g_pol),
    .vga_b_o(b_pol), .vga_hs_o(hs_pol), .vga_vs_o(vs_pol), .blank_o(blank_pol),
    .line_start_o(ls_pol), .frame_start_o(fs_pol)
  );

  typedef struct {
    int         k;
    logic [5:0] addr;
    logic       valid, hs, vs, blank;
    logic [2:0] rgb;
    logic       ls, fs;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int hs_fall1, hs_fall2, hs_low, ls_cnt, ls_k2, wait_i;
    logic hs_prev;
    logic [31:0] snap;

    vecs[0]  = '{1,  6'd0,  1, 1, 1, 1, 3'd0, 1, 1};
    vecs[1]  = '{2,  6'd1,  1, 1, 1, 1, 3'd0, 0, 0};
    vecs[2]  = '{3,  6'd2,  1, 1, 1, 0, 3'd1, 0, 0};
    vecs[3]  = '{4,  6'd3,  1, 1, 1, 0, 3'd2, 0, 0};
    vecs[4]  = '{6,  6'd5,  0, 1, 1, 0, 3'd4, 0, 0};
    vecs[5]  = '{7,  6'd6,  0, 1, 1, 1, 3'd0, 0, 0};
    vecs[6]  = '{8,  6'd8,  1, 0, 1, 1, 3'd0, 1, 0};
    vecs[7]  = '{9,  6'd9,  1, 1, 1, 1, 3'd0, 0, 0};
    vecs[8]  = '{10, 6'd10, 1, 1, 1, 0, 3'd3, 0, 0};
    vecs[9]  = '{13, 6'd13, 0, 1, 1, 0, 3'd6, 0, 0};
    vecs[10] = '{22, 6'd24, 0, 0, 1, 1, 3'd0, 1, 0};
    vecs[11] = '{31, 6'd34, 0, 1, 0, 1, 3'd0, 0, 0};
    vecs[12] = '{36, 6'd40, 0, 0, 0, 1, 3'd0, 1, 0};
    vecs[13] = '{38, 6'd42, 0, 1, 1, 1, 3'd0, 0, 0};
    vecs[14] = '{43, 6'd0,  1, 0, 1, 1, 3'd0, 1, 1};
    vecs[15] = '{46, 6'd3,  1, 1, 1, 0, 3'd2, 0, 0};

    rst_def_n = 1'b0; rst_sml_n = 1'b0; rst_pol_n = 1'b0;
    en_def = 1'b1; en_sml = 1'b1; en_pol = 1'b1;
    repeat (3) @(negedge clk);

    // ---- default instance: reset values, strobe latency, horizontal timing ----
    chk("def_rst_rgb", {r_def, g_def, b_def}, 3'b000);
    chk("def_rst_hs", hs_def, 1'b1);
    chk("def_rst_vs", vs_def, 1'b1);
    chk("def_rst_blank", blank_def, 1'b1);
    chk("def_rst_addr", addr_def, 22'd0);
    rst_def_n = 1'b1;
    hs_prev = 1'b1; hs_fall1 = 0; hs_fall2 = 0; hs_low = 0; ls_cnt = 0; ls_k2 = 0;
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clk);
      if (k == 1) chk("def_fs_k1", fs_def, 1'b0);
      if (k == 2) begin
        chk("def_fs_k2", fs_def, 1'b1);
        chk("def_ls_k2", ls_def, 1'b1);
      end
      if (k == 3) begin
        chk("def_fs_k3", fs_def, 1'b0);
        chk("def_blank_k3", blank_def, 1'b1);
      end
      if (k == 4) begin
        chk("def_blank_k4", blank_def, 1'b0);
        chk("def_rgb_k4", {r_def, g_def, b_def}, 3'b101);
      end
      if (k == 1283) chk("def_blank_k1283", blank_def, 1'b0);
      if (k == 1284) begin
        chk("def_blank_k1284", blank_def, 1'b1);
        chk("def_rgb_k1284", {r_def, g_def, b_def}, 3'b000);
      end
      if (ls_def) begin
        ls_cnt++;
        if (ls_cnt == 2) ls_k2 = k;
      end
      if (!hs_def && hs_prev) begin
        if (hs_fall1 == 0) hs_fall1 = k;
        else if (hs_fall2 == 0) hs_fall2 = k;
      end
      if (!hs_def && k < 2000) hs_low++;
      hs_prev = hs_def;
    end
    chk("def_hs_first_fall", hs_fall1, 1316);
    chk("def_hs_width", hs_low, 192);
    chk("def_hs_period", hs_fall2 - hs_fall1, 1600);
    chk("def_ls_second", ls_k2, 1602);
    rst_def_n = 1'b0;

    // ---- small instance: table over the first frame and a bit ----
    rst_sml_n = 1'b1;
    for (int k = 1; k <= 46; k++) begin
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
        if (vecs[i].k == k) begin
          chk($sformatf("sml_addr_k%0d", k), addr_sml, vecs[i].addr);
          chk($sformatf("sml_valid_k%0d", k), valid_sml, vecs[i].valid);
          chk($sformatf("sml_hs_k%0d", k), hs_sml, vecs[i].hs);
          chk($sformatf("sml_vs_k%0d", k), vs_sml, vecs[i].vs);
          chk($sformatf("sml_blank_k%0d", k), blank_sml, vecs[i].blank);
          chk($sformatf("sml_rgb_k%0d", k), {r_sml, g_sml, b_sml}, vecs[i].rgb);
          chk($sformatf("sml_ls_k%0d", k), ls_sml, vecs[i].ls);
          chk($sformatf("sml_fs_k%0d", k), fs_sml, vecs[i].fs);
        end
      end
    end

    // ---- freeze at x=2 for 10 cycles ----
    rst_sml_n = 1'b0;
    @(negedge clk);
    rst_sml_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("frz_addr_before", addr_sml, 6'd2);
    snap = {addr_sml, valid_sml, r_sml, g_sml, b_sml, hs_sml, vs_sml, blank_sml};
    en_sml = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("frz_hold_%0d", i),
          {addr_sml, valid_sml, r_sml, g_sml, b_sml, hs_sml, vs_sml, blank_sml}, snap);
      chk($sformatf("frz_strobes_%0d", i), {ls_sml, fs_sml}, 2'b00);
    end
    en_sml = 1'b1;
    @(negedge clk);
    chk("frz_resume_addr", addr_sml, 6'd3);
    chk("frz_resume_rgb", {r_sml, g_sml, b_sml}, 3'd2);

    // ---- asynchronous reset mid-frame at (2,2) ----
    wait_i = 0;
    while (addr_sml != 6'd18 && wait_i < 60) begin
      @(negedge clk);
      wait_i++;
    end
    chk("mid_reached", addr_sml, 6'd18);
    chk("mid_rgb_before", {r_sml, g_sml, b_sml}, 3'd5);
    @(posedge clk);
    #2 rst_sml_n = 1'b0;
    #1;
    chk("mid_rst_addr", addr_sml, 6'd0);
    chk("mid_rst_valid", valid_sml, 1'b0);
    chk("mid_rst_rgb", {r_sml, g_sml, b_sml}, 3'd0);
    chk("mid_rst_sync", {hs_sml, vs_sml}, 2'b11);
    chk("mid_rst_blank", blank_sml, 1'b1);
    @(negedge clk);
    rst_sml_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_fs", fs_sml, 1'b1);
    chk("mid_rel_addr", addr_sml, 6'd0);
    @(negedge clk);
    chk("mid_rel_fs_drop", fs_sml, 1'b0);
    chk("mid_rel_addr2", addr_sml, 6'd1);

    // ---- polarity and colour width ----
    chk("pol_rst_hs", hs_pol, 1'b0);
    chk("pol_rst_vs", vs_pol, 1'b0);
    rst_pol_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (k == 2) begin
        chk("pol_r", r_pol, 4'hA);
        chk("pol_g", g_pol, 4'h5);
        chk("pol_b", b_pol, 4'hC);
        chk("pol_blank", blank_pol, 1'b0);
      end
      if (k == 6) chk("pol_rgb_blanking", {r_pol, g_pol, b_pol}, 12'h000);
      if (k == 7) chk("pol_hs_on", hs_pol, 1'b1);
      if (k == 8) chk("pol_hs_off", hs_pol, 1'b0);
      if (k == 29) chk("pol_vs_off", vs_pol, 1'b0);
      if (k == 30) chk("pol_vs_on", vs_pol, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
